// File: rtl/addsub_serial.sv
// Chunk-serial adder/subtractor.
// An accepted operation is processed CHUNK bits per clock, LSB chunk first,
// over NCHUNK = WIDTH/CHUNK cycles. The result and its flags are then held
// until the consumer takes them with out_valid/out_ready.
// Subtraction is done as A + ~B + 1: the operand B is inverted when it is
// latched, and the running carry is preset to 1.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // The counter must hold NCHUNK itself, so it can step past the last chunk without wrapping.
  localparam int CW = (NCHUNK < 1) ? 1 : $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             run_carry;
  logic [CW-1:0]    cnt;
  logic             in_ready_q;

  int               base;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] y_next;

  // Adds the current chunk and builds the result word with that chunk merged in.
  always_comb begin
    base   = (int'(cnt) < NCHUNK) ? int'(cnt) * CHUNK : 0;
    a_c    = a_q[base +: CHUNK];
    b_c    = b_q[base +: CHUNK];
    sum    = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(run_carry);
    s_c    = sum[CHUNK-1:0];
    c_out  = sum[CHUNK];
    c_msb  = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    y_next = Y;
    y_next[base +: CHUNK] = s_c;
  end

  // Control FSM with the operand, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      run_carry  <= 1'b0;
      cnt        <= '0;
      Y          <= '0;
      carry      <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
      neg        <= 1'b0;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B ^ {WIDTH{sub}};
            run_carry  <= sub;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          Y         <= y_next;
          run_carry <= c_out;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            carry     <= c_out;
            ovf       <= c_msb ^ c_out;
            zero      <= (y_next == '0);
            neg       <= s_c[CHUNK-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Readiness is masked by rst, so no request is ever offered while reset is held.
  assign in_ready = in_ready_q & ~rst;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial.
// Three instances are built at WIDTH=16 with CHUNK values of 4, 16 and 1.
// All expected results come from a reference model that uses plain integer arithmetic.
module tb_addsub_serial;

  function automatic int chunkOf(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 1;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic        sub_s       [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic        carry_s     [3];
  logic        ovf_s       [3];
  logic        zero_s      [3];
  logic        neg_s       [3];
  logic [15:0] a_s         [3];
  logic [15:0] b_s         [3];
  logic [15:0] y_s         [3];

  int compared   = 0;
  int mismatched = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    addsub_serial #(.WIDTH(16), .CHUNK(chunkOf(g))) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .A         (a_s[g]),
      .B         (b_s[g]),
      .sub       (sub_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .Y         (y_s[g]),
      .carry     (carry_s[g]),
      .ovf       (ovf_s[g]),
      .zero      (zero_s[g]),
      .neg       (neg_s[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] y;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
    int          lat;
  } vec_t;

  // Reference result packed as {carry, ovf, zero, neg, Y}.
  function automatic logic [19:0] refModel(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ua, ub, sa, sb, r, sr;
    logic [15:0] y;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? ua - ub : ua + ub;
    sr = s ? sa - sb : sa + sb;
    y  = 16'(r);
    c  = s ? (ua >= ub) : (r > 65535);
    o  = (sr > 32767) || (sr < -32768);
    return {c, o, (y == 16'h0000), y[15], y};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operation, scrambles the inputs after it is accepted, and waits for the result.
  // Returns at the negedge where out_valid is first seen; lat is -1 if no result arrives.
  task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b,
                               input logic s, output int lat);
    int guard;
    guard = 0;
    while (!in_ready_s[k] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid_s[k] = 1'b1;
    a_s[k]        = a;
    b_s[k]        = b;
    sub_s[k]      = s;
    @(negedge clk);
    in_valid_s[k] = 1'b0;
    a_s[k]        = 16'($urandom);
    b_s[k]        = 16'($urandom);
    sub_s[k]      = ~s;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      in_valid_s[k] = 1'($urandom);
      if (out_valid_s[k]) break;
    end
    in_valid_s[k] = 1'b0;
    if (!out_valid_s[k]) lat = -1;
  endtask

  task automatic checkAll(input int k, input string name, input int lat, input int elat,
                          input logic [19:0] exp);
    checkOutput($sformatf("%s latency", name), lat, elat);
    checkOutput($sformatf("%s Y", name), y_s[k], exp[15:0]);
    checkOutput($sformatf("%s flags c/o/z/n", name),
                {carry_s[k], ovf_s[k], zero_s[k], neg_s[k]}, exp[19:16]);
  endtask

  task automatic consume(input int k, input string name);
    out_ready_s[k] = 1'b1;
    @(negedge clk);
    out_ready_s[k] = 1'b0;
    checkOutput($sformatf("%s release valid/ready", name),
                {out_valid_s[k], in_ready_s[k]}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl [11];
    int          lat;
    logic [19:0] snap;
    logic        seen;
    logic [15:0] ra, rb;
    logic        rs;

    tbl[0]  = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    tbl[1]  = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    tbl[2]  = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    tbl[3]  = '{0, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    tbl[4]  = '{0, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    tbl[5]  = '{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    tbl[6]  = '{0, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    tbl[7]  = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[8]  = '{2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16};
    tbl[9]  = '{2, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    tbl[10] = '{1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b0;
      sub_s[k]       = 1'b0;
      a_s[k]         = 16'h0;
      b_s[k]         = 16'h0;
    end

    // Reset state, then the ready handshake once rst is released.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("reset state inst%0d", k),
                  {in_ready_s[k], out_valid_s[k], carry_s[k], ovf_s[k], zero_s[k], neg_s[k], y_s[k]},
                  22'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("ready after reset inst%0d", k), in_ready_s[k], 1'b1);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].s, lat);
      checkAll(tbl[i].k, $sformatf("vec%0d", i), lat, tbl[i].lat,
               {tbl[i].c, tbl[i].o, tbl[i].z, tbl[i].n, tbl[i].y});
      consume(tbl[i].k, $sformatf("vec%0d", i));
    end

    // Result held in DONE while the consumer stalls, with a stray request pulsed.
    applyStimulus(0, 16'h1234, 16'h4321, 1'b0, lat);
    checkAll(0, "stall", lat, 4, refModel(16'h1234, 16'h4321, 1'b0));
    snap = {carry_s[0], ovf_s[0], zero_s[0], neg_s[0], y_s[0]};
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid_s[0] = 1'b1;
        a_s[0]        = 16'hFFFF;
        b_s[0]        = 16'hFFFF;
      end
      if (i == 4) in_valid_s[0] = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("stall hold cycle%0d", i),
                  {out_valid_s[0], in_ready_s[0], carry_s[0], ovf_s[0], zero_s[0], neg_s[0], y_s[0]},
                  {2'b10, snap});
    end
    in_valid_s[0] = 1'b0;
    consume(0, "stall");
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid_s[0];
    end
    checkOutput("stall pulsed op ignored", seen, 1'b0);

    // Reset two cycles into CALC discards the operation.
    in_valid_s[0] = 1'b1;
    a_s[0]        = 16'hABCD;
    b_s[0]        = 16'h1111;
    sub_s[0]      = 1'b0;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset mid-calc state",
                {out_valid_s[0], in_ready_s[0], carry_s[0], ovf_s[0], zero_s[0], neg_s[0], y_s[0]},
                22'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset mid-calc ready", in_ready_s[0], 1'b1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid_s[0];
    end
    checkOutput("reset mid-calc no stale valid", seen, 1'b0);
    applyStimulus(0, 16'h1234, 16'h1111, 1'b0, lat);
    checkAll(0, "post-reset op", lat, 4, {4'b0000, 16'h2345});
    consume(0, "post-reset op");

    // Random operations on every build, with random consumer stalls.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 30; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (i % 7 == 0) rb = ra;
        if (i % 11 == 1) ra = 16'h8000;
        applyStimulus(k, ra, rb, rs, lat);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checkAll(k, $sformatf("rand inst%0d #%0d", k, i), lat, 16 / chunkOf(k), refModel(ra, rb, rs));
        consume(k, $sformatf("rand inst%0d #%0d", k, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
